acc_control_fsm: RTL and testbench
==================================

// Module: acc_control_fsm
// PURPOSE
//  Multi-cycle control FSM for the 8-bit accumulator datapath (5-bit PC, 3-bit opcode, 5-bit operand).
//  Sequences fetch/decode/memory/execute and drives ld_ac, ac_src, pc_src, plus PC load and data-memory handshake.
//  Sits beside the datapath; receives decoded opcode and AC-zero flag, and handshakes with a variable-latency data memory.
// PARAMETERS
//  ACK_TIMEOUT  15  max cycles MEM waits for dm_ack before error (used only with CTRL_WATCHDOG_EN)
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk        in   1      single system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  run        in   1      1 = execute; sampled in IDLE and NEXT
//  opcode     in   3      instruction[7:5] from datapath
//  ac_zero    in   1      1 when accumulator == 8'h00
//  dm_ack     in   1      data memory done; read data valid same cycle
//  ir_ld      out  1      capture im_dbus into instruction register
//  pc_ld      out  1      PC load enable
//  pc_src     out  1      0 = PC+1, 1 = operand[4:0]
//  ld_ac      out  1      accumulator load enable
//  ac_src     out  1      0 = ALU result, 1 = dm_out_dbus
//  dm_req     out  1      data memory request, held until dm_ack
//  dm_we      out  1      write qualifier, valid only while dm_req=1
//  halted     out  1      HALT state reached
//  err        out  1      watchdog timeout (tied 0 without CTRL_WATCHDOG_EN)
//  instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Opcodes: 000 HLT, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 AND, 110 JMP, 111 SKZ.
//  Reset (reset=0, any time incl. mid-access): state IDLE; all outputs 0; instr_cnt 0; dm_req dropped immediately.
//  Outputs are combinational from state (+ dm_ack/ac_zero/opcode where noted); unlisted outputs are 0.
//  IDLE:   run=1 -> FETCH, else stay.
//  FETCH:  ir_ld=1 -> DECODE (1 cycle).
//  DECODE: HLT -> HALT; LDA/STA/ADD/SUB/AND -> MEM; JMP/SKZ -> EXEC.
//  MEM:    dm_req=1; dm_we=1 for STA only. Stay while dm_ack=0.
//    On dm_ack=1 (same cycle): LDA ld_ac=1, ac_src=1; ADD/SUB/AND ld_ac=1, ac_src=0; STA no load. -> NEXT.
//  EXEC:   JMP pc_ld=1, pc_src=1 -> FETCH (no PC+1). SKZ: ac_zero=1 pc_ld=1, pc_src=0 (skip) -> NEXT; else -> NEXT.
//  NEXT:   pc_ld=1, pc_src=0; instr_cnt+1; run=1 -> FETCH, run=0 -> IDLE (pause only at instruction boundary).
//  JMP retires in EXEC: instr_cnt+1 there.
//  HALT:   halted=1; stays until reset; run ignored.
//  dm_ack outside MEM: ignored.
//  run deasserted mid-instruction: current instruction completes.
//  instr_cnt wraps 2^CNT_W-1 -> 0 silently.
//  Latency: LDA/STA/ALU = 4 cycles + memory wait; JMP = 3; SKZ = 4.
//  PC wraps 31 -> 0 in datapath; controller does not check.
// CONFIGURATION
//  CTRL_WATCHDOG_EN defined: wait counter cleared on MEM entry, incremented each MEM cycle with dm_ack=0.
//    On reaching ACK_TIMEOUT: -> ERR state; dm_req=0; err=1; sticky until reset.
//    dm_ack on the timeout cycle wins (normal completion).
//  CTRL_WATCHDOG_EN undefined: no counter, no ERR state, err tied 0; MEM waits indefinitely.
// TESTING
//  1. reset=0 mid-MEM (dm_req=1) -> all outputs 0 same cycle; after release with run=1, FETCH on first clk.
//  2. LDA, dm_ack after 3 wait cycles -> dm_req high 4 cycles, ld_ac=ac_src=1 only in the ack cycle, then pc_ld in NEXT, instr_cnt=1.
//  3. STA, immediate ack -> dm_req=dm_we=1 for 1 cycle, ld_ac never asserted, NEXT follows.
//  4. SKZ with ac_zero=1 -> pc_ld,pc_src=0 in EXEC and NEXT (PC+2); ac_zero=0 -> only NEXT (PC+1).
//  5. JMP -> pc_ld=1, pc_src=1 in EXEC, next state FETCH; run=0 at NEXT -> IDLE; HLT -> halted=1 and stays despite run toggling.
//  6. CTRL_WATCHDOG_EN, ACK_TIMEOUT=15, no dm_ack -> err=1 after 15 MEM cycles, dm_req=0; ack on cycle 15 -> normal, err=0.

Source files
------------

// File: rtl/acc_control_fsm.sv
// -----------------------------------------------------------------------------
// acc_control_fsm
//   Multi-cycle control FSM for the 8-bit accumulator datapath (5-bit PC,
//   3-bit opcode, 5-bit operand). It sequences each instruction through
//   fetch / decode / memory / execute and issues the datapath load and select
//   strobes. It also handshakes with a variable-latency data memory.
//
// Parameters
//   ACK_TIMEOUT  maximum number of MEM cycles spent waiting for dm_ack
//                (only used when CTRL_WATCHDOG_EN is defined)
//   CNT_W        width of the retired-instruction counter
//
// Build option
//   CTRL_WATCHDOG_EN  when defined, adds a dm_ack watchdog and a sticky ERR
//                     state. When undefined, MEM waits forever and err is 0.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   run        1 = execute; sampled in IDLE and NEXT only
//   opcode     instruction[7:5] from the datapath instruction register
//   ac_zero    accumulator == 0
//   dm_ack     data memory done; read data valid in the same cycle
//   ir_ld      capture instruction bus into IR
//   pc_ld      PC load enable
//   pc_src     0 = PC+1, 1 = operand
//   ld_ac      accumulator load enable
//   ac_src     0 = ALU result, 1 = data memory read bus
//   dm_req     data memory request, held until dm_ack
//   dm_we      write qualifier, meaningful only while dm_req = 1
//   halted     HALT state reached
//   err        dm_ack watchdog expired (sticky until reset)
//   instr_cnt  retired-instruction count, wraps silently
// -----------------------------------------------------------------------------
module acc_control_fsm #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             ac_zero,
  input  logic             dm_ack,
  output logic             ir_ld,
  output logic             pc_ld,
  output logic             pc_src,
  output logic             ld_ac,
  output logic             ac_src,
  output logic             dm_req,
  output logic             dm_we,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_LDA = 3'd1,
    OP_STA = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_AND = 3'd5,
    OP_JMP = 3'd6,
    OP_SKZ = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_NEXT,
`ifdef CTRL_WATCHDOG_EN
    S_HALT,
    S_ERR
`else
    S_HALT
`endif
  } state_t;

  // Elaboration-time sanity checks on the parameters.
  if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
    $error("acc_control_fsm: ACK_TIMEOUT must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("acc_control_fsm: CNT_W must be at least 1");
  end

  state_t           r_state;
  state_t           w_next_state;
  opcode_t          w_op;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_cnt;

  assign w_op = opcode_t'(opcode);

`ifdef CTRL_WATCHDOG_EN
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_timeout;

  // The counter only advances while stalled in MEM, so any other state acts
  // as the "cleared on MEM entry" point. The last permitted wait cycle is the
  // one where the count already holds ACK_TIMEOUT-1. An ack in that cycle
  // still completes normally, because the MEM branch checks dm_ack first.
  assign w_timeout = (r_wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_MEM && !dm_ack) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end
`endif

  // NOTE: the state and counter registers use non-blocking assignments. Every
  // flop then samples the pre-edge values, whatever order the blocks run in.
  // The outputs decode from r_state, so the asynchronous reset clears them in
  // the same cycle, including a dm_req that is still outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
    end
  end

  assign instr_cnt = r_instr_cnt;

  // NOTE: every signal written here gets a default before the case
  // statement. Without that, a path that skips an assignment would make
  // synthesis infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    ir_ld        = 1'b0;
    pc_ld        = 1'b0;
    pc_src       = 1'b0;
    ld_ac        = 1'b0;
    ac_src       = 1'b0;
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) w_next_state = S_FETCH;
      end

      S_FETCH: begin
        ir_ld        = 1'b1;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        case (w_op)
          OP_HLT:         w_next_state = S_HALT;
          OP_JMP, OP_SKZ: w_next_state = S_EXEC;
          default:        w_next_state = S_MEM;
        endcase
      end

      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = (w_op == OP_STA);
        if (dm_ack) begin
          // Read data is valid in the ack cycle, so the load happens here
          // rather than one cycle later in NEXT.
          case (w_op)
            OP_LDA: begin
              ld_ac  = 1'b1;
              ac_src = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              ld_ac = 1'b1;
            end
            default: ;
          endcase
          w_next_state = S_NEXT;
        end
`ifdef CTRL_WATCHDOG_EN
        else if (w_timeout) begin
          w_next_state = S_ERR;
        end
`endif
      end

      S_EXEC: begin
        if (w_op == OP_JMP) begin
          // A jump loads the target directly, so it skips the PC+1 in NEXT
          // and retires here instead.
          pc_ld        = 1'b1;
          pc_src       = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          // SKZ: an extra PC+1 here, plus the one in NEXT, skips one word.
          pc_ld        = ac_zero;
          w_next_state = S_NEXT;
        end
      end

      S_NEXT: begin
        pc_ld        = 1'b1;
        w_retire     = 1'b1;
        w_next_state = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        halted = 1'b1;
      end

`ifdef CTRL_WATCHDOG_EN
      S_ERR: begin
        err = 1'b1;
      end
`endif

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_acc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_acc_control_fsm
//   Directed, table-driven bench for acc_control_fsm. Each table row is one
//   clock cycle. Its inputs are driven on the falling edge, and the outputs
//   are compared shortly after, before the next rising edge. A few
//   hand-written sequences cover the corner cases: reset in the middle of a
//   cycle, and the watchdog when CTRL_WATCHDOG_EN is defined. CNT_W is
//   reduced to 3 so that the retired-instruction counter wraps inside the
//   table.
// -----------------------------------------------------------------------------
module tb_acc_control_fsm;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_SKZ = 3'd7;

  // Expected-flag bits, ordered {ir_ld,pc_ld,pc_src,ld_ac,ac_src,dm_req,dm_we,halted,err}
  localparam logic [8:0] F_NONE  = 9'h000;
  localparam logic [8:0] F_IR    = 9'h100;
  localparam logic [8:0] F_PCLD  = 9'h080;
  localparam logic [8:0] F_PCSRC = 9'h040;
  localparam logic [8:0] F_LDAC  = 9'h020;
  localparam logic [8:0] F_ACSRC = 9'h010;
  localparam logic [8:0] F_REQ   = 9'h008;
  localparam logic [8:0] F_WE    = 9'h004;
  localparam logic [8:0] F_HALT  = 9'h002;
  localparam logic [8:0] F_ERR   = 9'h001;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       run     = 1'b0;
  logic [2:0] opcode  = 3'd0;
  logic       ac_zero = 1'b0;
  logic       dm_ack  = 1'b0;
  logic       ir_ld, pc_ld, pc_src, ld_ac, ac_src, dm_req, dm_we, halted, err;
  logic [2:0] instr_cnt;

  acc_control_fsm #(.ACK_TIMEOUT(15), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .ac_zero   (ac_zero),
    .dm_ack    (dm_ack),
    .ir_ld     (ir_ld),
    .pc_ld     (pc_ld),
    .pc_src    (pc_src),
    .ld_ac     (ld_ac),
    .ac_src    (ac_src),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .halted    (halted),
    .err       (err),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       run;
    logic [2:0] op;
    logic       az;
    logic       ack;
    logic [8:0] flags;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic rn, input logic [2:0] op,
                              input logic az, input logic ack,
                              input logic [8:0] flags, input logic [2:0] cnt);
    vec_t v;
    v.rst = r; v.run = rn; v.op = op; v.az = az; v.ack = ack;
    v.flags = flags; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [11:0] dut_outs();
    return {ir_ld, pc_ld, pc_src, ld_ac, ac_src, dm_req, dm_we, halted, err, instr_cnt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
               name, act[11:3], act[2:0], exp[11:3], exp[2:0]);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    reset   = v.rst;
    run     = v.run;
    opcode  = v.op;
    ac_zero = v.az;
    dm_ack  = v.ack;
    #1;
    check(name, dut_outs(), {v.flags, v.cnt});
  endtask

  initial begin
    // rst, run, opcode, ac_zero, dm_ack | expected flags, instr_cnt
    vecs.push_back(mk(0,0,OP_LDA,0,0, F_NONE, 0));                  // reset held
    vecs.push_back(mk(1,0,OP_LDA,0,0, F_NONE, 0));                  // IDLE, run=0
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_NONE, 0));                  // IDLE -> FETCH
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_IR, 0));                    // FETCH
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_NONE, 0));                  // DECODE
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_REQ, 0));                   // MEM wait 1
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_REQ, 0));                   // MEM wait 2
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_REQ, 0));                   // MEM wait 3
    vecs.push_back(mk(1,1,OP_LDA,0,1, F_REQ|F_LDAC|F_ACSRC, 0));    // MEM ack
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_PCLD, 0));                  // NEXT
    vecs.push_back(mk(1,1,OP_STA,0,0, F_IR, 1));                    // FETCH STA
    vecs.push_back(mk(1,1,OP_STA,0,0, F_NONE, 1));
    vecs.push_back(mk(1,1,OP_STA,0,1, F_REQ|F_WE, 1));              // immediate ack
    vecs.push_back(mk(1,1,OP_STA,0,0, F_PCLD, 1));
    vecs.push_back(mk(1,1,OP_ADD,0,0, F_IR, 2));                    // ADD
    vecs.push_back(mk(1,1,OP_ADD,0,0, F_NONE, 2));
    vecs.push_back(mk(1,1,OP_ADD,0,0, F_REQ, 2));
    vecs.push_back(mk(1,1,OP_ADD,0,1, F_REQ|F_LDAC, 2));
    vecs.push_back(mk(1,1,OP_ADD,0,0, F_PCLD, 2));
    vecs.push_back(mk(1,1,OP_SKZ,1,0, F_IR, 3));                    // SKZ taken
    vecs.push_back(mk(1,1,OP_SKZ,1,0, F_NONE, 3));
    vecs.push_back(mk(1,1,OP_SKZ,1,0, F_PCLD, 3));                  // EXEC skip
    vecs.push_back(mk(1,1,OP_SKZ,1,0, F_PCLD, 3));                  // NEXT
    vecs.push_back(mk(1,1,OP_SKZ,0,0, F_IR, 4));                    // SKZ not taken
    vecs.push_back(mk(1,1,OP_SKZ,0,0, F_NONE, 4));
    vecs.push_back(mk(1,1,OP_SKZ,0,1, F_NONE, 4));                  // EXEC, stray ack
    vecs.push_back(mk(1,1,OP_SKZ,0,0, F_PCLD, 4));
    vecs.push_back(mk(1,1,OP_JMP,0,0, F_IR, 5));                    // JMP
    vecs.push_back(mk(1,1,OP_JMP,0,0, F_NONE, 5));
    vecs.push_back(mk(1,1,OP_JMP,0,0, F_PCLD|F_PCSRC, 5));          // EXEC -> FETCH
    vecs.push_back(mk(1,0,OP_SUB,0,0, F_IR, 6));                    // run drops mid-instr
    vecs.push_back(mk(1,0,OP_SUB,0,0, F_NONE, 6));
    vecs.push_back(mk(1,0,OP_SUB,0,1, F_REQ|F_LDAC, 6));
    vecs.push_back(mk(1,0,OP_SUB,0,0, F_PCLD, 6));                  // NEXT -> IDLE
    vecs.push_back(mk(1,0,OP_SUB,0,0, F_NONE, 7));                  // IDLE
    vecs.push_back(mk(1,1,OP_SUB,0,0, F_NONE, 7));                  // IDLE -> FETCH
    vecs.push_back(mk(1,1,OP_AND,0,1, F_IR, 7));                    // stray ack in FETCH
    vecs.push_back(mk(1,1,OP_AND,0,0, F_NONE, 7));
    vecs.push_back(mk(1,1,OP_AND,0,1, F_REQ|F_LDAC, 7));
    vecs.push_back(mk(1,1,OP_AND,0,0, F_PCLD, 7));                  // count wraps 7 -> 0
    vecs.push_back(mk(1,1,OP_HLT,0,0, F_IR, 0));                    // HLT
    vecs.push_back(mk(1,1,OP_HLT,0,0, F_NONE, 0));
    vecs.push_back(mk(1,0,OP_HLT,0,0, F_HALT, 0));
    vecs.push_back(mk(1,1,OP_HLT,0,0, F_HALT, 0));                  // run ignored
    vecs.push_back(mk(1,0,OP_HLT,0,1, F_HALT, 0));
    vecs.push_back(mk(0,1,OP_HLT,0,0, F_NONE, 0));                  // reset clears HALT
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_NONE, 0));                  // IDLE -> FETCH
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_IR, 0));                    // FETCH on first clk
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_NONE, 0));
    vecs.push_back(mk(1,1,OP_LDA,0,0, F_REQ, 0));                   // MEM, request open

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted mid-cycle while dm_req is high: outputs drop immediately.
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_mem", dut_outs(), {F_NONE, 3'd0});
    apply("release_idle",      mk(1,1,OP_LDA,0,0, F_NONE, 0));
    apply("fetch_after_reset", mk(1,1,OP_LDA,0,0, F_IR, 0));

`ifdef CTRL_WATCHDOG_EN
    // No ack at all: 15 MEM cycles with a request, then a sticky error.
    apply("wd_reset", mk(0,0,OP_LDA,0,0, F_NONE, 0));
    apply("wd_idle",  mk(1,1,OP_LDA,0,0, F_NONE, 0));
    apply("wd_fetch", mk(1,1,OP_LDA,0,0, F_IR, 0));
    apply("wd_dec",   mk(1,1,OP_LDA,0,0, F_NONE, 0));
    for (int k = 1; k <= 15; k++) apply($sformatf("wd_wait%0d", k), mk(1,1,OP_LDA,0,0, F_REQ, 0));
    apply("wd_err",        mk(1,1,OP_LDA,0,0, F_ERR, 0));
    apply("wd_err_sticky", mk(1,1,OP_LDA,0,1, F_ERR, 0));

    // Ack arriving on the 15th MEM cycle completes normally.
    apply("wd2_reset", mk(0,0,OP_LDA,0,0, F_NONE, 0));
    apply("wd2_idle",  mk(1,1,OP_LDA,0,0, F_NONE, 0));
    apply("wd2_fetch", mk(1,1,OP_LDA,0,0, F_IR, 0));
    apply("wd2_dec",   mk(1,1,OP_LDA,0,0, F_NONE, 0));
    for (int k = 1; k <= 14; k++) apply($sformatf("wd2_wait%0d", k), mk(1,1,OP_LDA,0,0, F_REQ, 0));
    apply("wd2_ack",   mk(1,1,OP_LDA,0,1, F_REQ|F_LDAC|F_ACSRC, 0));
    apply("wd2_next",  mk(1,1,OP_LDA,0,0, F_PCLD, 0));
    apply("wd2_fetch2", mk(1,1,OP_LDA,0,0, F_IR, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
